// File: rtl/sbqm_queue_ctrl_if.sv
// Photocell pulse / occupancy bus between the sensor side (master) and the
// Smart Bank Queue Manager queue controller (slave).
interface sbqm_queue_ctrl_if #(
  parameter int PW = 3,
  parameter int WW = 5
);
  logic          entry_pulse;
  logic          exit_pulse;
  logic [1:0]    tcount;
  logic [PW-1:0] pcount;
  logic          empty;
  logic          full;
  logic [WW-1:0] wtime;
  logic          ovf_err;
  logic          unf_err;

  modport master (
    output entry_pulse, exit_pulse, tcount,
    input  pcount, empty, full, wtime, ovf_err, unf_err
  );

  modport slave (
    input  entry_pulse, exit_pulse, tcount,
    output pcount, empty, full, wtime, ovf_err, unf_err
  );
endinterface

// File: rtl/sbqm_queue_ctrl.sv
// Queue controller: pairs photocell edge pulses into passes, tracks occupancy
// with full/empty flags and produces a registered estimated wait time.
module sbqm_queue_ctrl #(
  parameter int MAX_P = 7,
  parameter int PW    = 3,
  parameter int SVC_T = 3,
  parameter int WW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  sbqm_queue_ctrl_if.slave  bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] BLOCKED = 1'b1;

  localparam int              NW     = 16;
  localparam logic [PW-1:0]   PMAX   = PW'(MAX_P);
  localparam logic [NW-1:0]   W_SAT  = NW'((1 << WW) - 1);

  logic [0:0]    r_entry_st;
  logic [0:0]    r_exit_st;
  logic [PW-1:0] r_pcount;
  logic [WW-1:0] r_wtime;
  logic          r_ovf_err;
  logic          r_unf_err;

  logic          w_ev_in;
  logic          w_ev_out;
  logic [NW-1:0] w_num;
  logic [NW-1:0] w_quot;
  logic [WW-1:0] w_wtime;

  // A pass completes on the second edge pulse of a sensor (beam restored).
  assign w_ev_in  = bus.entry_pulse && (r_entry_st == BLOCKED);
  assign w_ev_out = bus.exit_pulse  && (r_exit_st  == BLOCKED);

  // NOTE: async reset clears every register here; sequential state uses
  // non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entry_st <= IDLE;
      r_exit_st  <= IDLE;
      r_pcount   <= '0;
      r_ovf_err  <= 1'b0;
      r_unf_err  <= 1'b0;
      r_wtime    <= '0;
    end else begin
      if (bus.entry_pulse) r_entry_st <= ~r_entry_st;
      if (bus.exit_pulse)  r_exit_st  <= ~r_exit_st;

      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
      if (w_ev_in && !w_ev_out) begin
        if (r_pcount < PMAX) r_pcount  <= r_pcount + 1'b1;
        else                 r_ovf_err <= 1'b1;
      end else if (w_ev_out && !w_ev_in) begin
        if (r_pcount != '0)  r_pcount  <= r_pcount - 1'b1;
        else                 r_unf_err <= 1'b1;
      end

      r_wtime <= w_wtime;
    end
  end

  // Wait estimate: SVC_T*(p+t-1)/t with t in 1..3, so the divider is a
  // constant-divisor select rather than a general divider.
  assign w_num = (NW'(r_pcount) + NW'(bus.tcount) - NW'(1)) * NW'(SVC_T);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_quot  = '0;
    w_wtime = '0;
    case (bus.tcount)
      2'd1:    w_quot = w_num;
      2'd2:    w_quot = w_num / NW'(2);
      2'd3:    w_quot = w_num / NW'(3);
      default: w_quot = W_SAT;
    endcase
    if (r_pcount == '0)     w_wtime = '0;
    else if (w_quot > W_SAT) w_wtime = W_SAT[WW-1:0];
    else                     w_wtime = w_quot[WW-1:0];
  end

  assign bus.pcount  = r_pcount;
  assign bus.empty   = (r_pcount == '0);
  assign bus.full    = (r_pcount == PMAX);
  assign bus.wtime   = r_wtime;
  assign bus.ovf_err = r_ovf_err;
  assign bus.unf_err = r_unf_err;

endmodule

// File: doc/sbqm_queue_ctrl.md
Name: sbqm_queue_ctrl

Overview:
- Consumer end of the photocell pulse interface in the Smart Bank Queue Manager.
- Takes the edge pulses from the entry and exit photocell blocks. Each sensor emits one pulse when its beam breaks and one when it restores.
- Pairs the pulses into completed person passes and maintains the queue occupancy count with full/empty flags.
- Computes a registered estimated wait time from occupancy and the number of active tellers.

Parameters:
- MAX_P, 7, maximum queue occupancy; count saturates here.
- PW, 3, width of pcount; must satisfy 2^PW > MAX_P.
- SVC_T, 3, service time per customer in minutes.
- WW, 5, width of wtime; the result saturates at 2^WW-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-low; rst=0 clears all state immediately.
- entry_pulse  input  1  one-cycle pulse from the entry photocell, one per beam edge.
- exit_pulse  input  1  one-cycle pulse from the exit photocell, one per beam edge.
- tcount  input  2  number of active tellers, 0..3.
- pcount  output  PW  current queue occupancy.
- empty  output  1  high when pcount==0.
- full  output  1  high when pcount==MAX_P.
- wtime  output  WW  estimated wait time in minutes.
- ovf_err  output  1  one-cycle pulse: an entry pass was rejected because the queue was full.
- unf_err  output  1  one-cycle pulse: an exit pass was rejected because the queue was empty.

Behaviour:
- Reset values (rst=0): both pass FSMs IDLE, pcount=0, empty=1, full=0, wtime=0, ovf_err=0, unf_err=0.
- Pass FSM: one per sensor (entry, exit), two states: IDLE (beam clear) and BLOCKED (beam broken).
  - IDLE + pulse -> BLOCKED; no event.
  - BLOCKED + pulse -> IDLE; a pass event (ev_in or ev_out) is asserted combinationally in that same cycle.
  - No pulse -> hold the current state.
- Occupancy update, on the same clock edge that samples the second pulse:
  - ev_in only: if pcount<MAX_P then pcount+1; else pcount holds and ovf_err=1 for one cycle.
  - ev_out only: if pcount>0 then pcount-1; else pcount holds and unf_err=1 for one cycle.
  - ev_in and ev_out together: pcount unchanged, no error, including at full and at empty.
  - Neither: hold.
- ovf_err and unf_err are registered and high for exactly one cycle per rejected pass; otherwise 0.
- empty and full are decoded from the registered pcount with no extra latency.
- wtime is registered and updates one clock edge after the pcount or tcount value it is based on:
  - pcount==0 -> 0.
  - pcount>0 and tcount==0 -> 2^WW-1 (no service).
  - otherwise floor(SVC_T*(pcount+tcount-1)/tcount), saturated at 2^WW-1.
  - Division is by 1, 2 or 3 only; implement as a constant-divisor select, not a general divider.
  - With the default parameters the maximum unsaturated value is 21 (pcount=7, tcount=1).
- A stray single pulse leaves its FSM in BLOCKED; the next pulse on that sensor completes the pass. There is no timeout.
- Reset mid-pass: the FSMs return to IDLE, so any half-completed pass is discarded.
- Pulses are assumed to be one cycle wide and synchronous to clk. A pulse held high for k cycles counts as k pulses.

Test Plan:
- Release rst, tcount=1; give 2 entry pulses 3 cycles apart -> pcount 0→1 on the edge sampling the 2nd pulse; empty 1→0; wtime=3 one edge later.
- 14 entry pulses (7 passes) with tcount=1 -> pcount=7, full=1, wtime=21. Sweep tcount=2 -> wtime=12; tcount=3 -> wtime=9; tcount=0 -> wtime=31. Each change appears one edge after tcount changes.
- At full, one more entry pass -> ovf_err high for exactly 1 cycle, pcount stays 7. At empty, one exit pass -> unf_err one cycle, pcount stays 0.
- pcount=3; entry and exit second pulses in the same cycle -> pcount stays 3, no error pulses. Repeat at pcount=7 and pcount=0 -> no change, no errors.
- One entry pulse only (FSM BLOCKED), then drive rst low mid-cycle -> all outputs reset immediately without waiting for a clock. After release, a single entry pulse leaves pcount=0; the following pulse increments it to 1.
